// File: rtl/rx_udp_unpack_if.sv
// Stream bundle for rx_udp_unpack: 32-bit datagram input (din*) with ready,
// 16-bit payload output (dout*) without backpressure.
interface rx_udp_unpack_if;
    logic [31:0] din;
    logic        din_sop;
    logic        din_eop;
    logic        din_vld;
    logic [1:0]  din_mty;
    logic        din_rdy;

    logic [15:0] dout;
    logic        dout_sop;
    logic        dout_eop;
    logic        dout_vld;
    logic        dout_mty;
    logic        dout_err;

    modport master (
        output din, din_sop, din_eop, din_vld, din_mty,
        input  din_rdy,
        input  dout, dout_sop, dout_eop, dout_vld, dout_mty, dout_err
    );

    modport slave (
        input  din, din_sop, din_eop, din_vld, din_mty,
        output din_rdy,
        output dout, dout_sop, dout_eop, dout_vld, dout_mty, dout_err
    );
endinterface

// File: rtl/rx_udp_unpack.sv
// UDP receive unpacker: checks ports, strips the 8-byte header, trims the payload
// to the UDP length and re-emits it as a 16-bit sop/eop/vld/mty stream.
module rx_udp_unpack #(
    parameter bit CHK_SPORT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           cfg_port_local,
    input  logic [15:0]           cfg_port_pc,
    rx_udp_unpack_if.slave        bus,
    output logic                  flag_port_err,
    output logic                  flag_len_err
);

    typedef enum logic [1:0] {IDLE, HDR1, PAYLOAD, DROP} state_t;

    state_t      state;
    logic [15:0] sport;
    logic [15:0] dport;
    logic [15:0] rem;
    logic [15:0] hold;
    logic        hold_pend;
    logic        hold_eop;
    logic        hold_mty;
    logic        hold_err;
    logic        started;

    logic        accept;
    logic [2:0]  avail;
    logic [2:0]  v;
    logic [15:0] rem_n;
    logic        last;
    logic        trunc;
    logic        port_ok;
    logic [15:0] len;
    logic [7:0]  b0, b1, b2, b3;

    // The only stall: a 3- or 4-byte word still owes its second beat.
    assign bus.din_rdy = !hold_pend;
    assign accept      = bus.din_vld && !hold_pend;

    assign b0  = bus.din[31:24];
    assign b1  = bus.din[23:16];
    assign b2  = bus.din[15:8];
    assign b3  = bus.din[7:0];
    assign len = bus.din[31:16];

    always_comb begin
        avail   = bus.din_eop ? (3'd4 - {1'b0, bus.din_mty}) : 3'd4;
        v       = (rem < {13'd0, avail}) ? rem[2:0] : avail;
        rem_n   = rem - {13'd0, v};
        last    = (rem_n == 16'd0) || bus.din_eop;
        trunc   = bus.din_eop && (rem_n != 16'd0);
        port_ok = (dport == cfg_port_local) && (!CHK_SPORT || (sport == cfg_port_pc));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            sport         <= '0;
            dport         <= '0;
            rem           <= '0;
            hold          <= '0;
            hold_pend     <= 1'b0;
            hold_eop      <= 1'b0;
            hold_mty      <= 1'b0;
            hold_err      <= 1'b0;
            started       <= 1'b0;
            bus.dout      <= '0;
            bus.dout_sop  <= 1'b0;
            bus.dout_eop  <= 1'b0;
            bus.dout_vld  <= 1'b0;
            bus.dout_mty  <= 1'b0;
            bus.dout_err  <= 1'b0;
            flag_port_err <= 1'b0;
            flag_len_err  <= 1'b0;
        end else begin
            bus.dout      <= '0;
            bus.dout_sop  <= 1'b0;
            bus.dout_eop  <= 1'b0;
            bus.dout_vld  <= 1'b0;
            bus.dout_mty  <= 1'b0;
            bus.dout_err  <= 1'b0;
            flag_port_err <= 1'b0;
            flag_len_err  <= 1'b0;

            if (hold_pend) begin
                bus.dout     <= hold;
                bus.dout_vld <= 1'b1;
                bus.dout_eop <= hold_eop;
                bus.dout_mty <= hold_mty;
                bus.dout_err <= hold_err;
                hold_pend    <= 1'b0;
            end else if (accept) begin
                if (bus.din_sop) begin
                    // A new sop closes any open datagram with an error terminator.
                    if (state == PAYLOAD && started) begin
                        bus.dout_vld <= 1'b1;
                        bus.dout_eop <= 1'b1;
                        bus.dout_err <= 1'b1;
                        bus.dout_mty <= 1'b1;
                    end
                    sport   <= bus.din[31:16];
                    dport   <= bus.din[15:0];
                    started <= 1'b0;
                    if (bus.din_eop) begin
                        flag_len_err <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        state <= HDR1;
                    end
                end else begin
                    case (state)
                        IDLE: ;
                        HDR1: begin
                            if (bus.din_eop) begin
                                flag_len_err <= 1'b1;
                                state        <= IDLE;
                            end else if (!port_ok) begin
                                flag_port_err <= 1'b1;
                                state         <= DROP;
                            end else if (len < 16'd8) begin
                                flag_len_err <= 1'b1;
                                state        <= DROP;
                            end else if (len == 16'd8) begin
                                state <= DROP;
                            end else begin
                                rem   <= len - 16'd8;
                                state <= PAYLOAD;
                            end
                        end
                        PAYLOAD: begin
                            bus.dout     <= {b0, (v >= 3'd2) ? b1 : 8'h00};
                            bus.dout_vld <= 1'b1;
                            bus.dout_sop <= !started;
                            started      <= 1'b1;
                            rem          <= rem_n;
                            if (v <= 3'd2) begin
                                bus.dout_eop <= last;
                                bus.dout_mty <= last && (v == 3'd1);
                                bus.dout_err <= trunc;
                            end else begin
                                hold      <= {b2, (v == 3'd4) ? b3 : 8'h00};
                                hold_pend <= 1'b1;
                                hold_eop  <= last;
                                hold_mty  <= (v == 3'd3);
                                hold_err  <= trunc;
                            end
                            if (last) begin
                                state <= bus.din_eop ? IDLE : DROP;
                            end
                        end
                        DROP: begin
                            if (bus.din_eop) begin
                                state <= IDLE;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/rx_udp_unpack.md
# rx_udp_unpack

Receive-side counterpart of the UDP packer on the transmit path. Accepts a 32-bit Avalon-ST UDP datagram (header plus payload) from the IP analyser and checks source and destination ports against configuration. It strips the 8-byte UDP header, trims payload to the UDP length field (removing Ethernet pad), and emits the payload as a 16-bit stream with sop/eop/vld/mty. It sits between the IP analyser and the user receive port, upstream of the error filter.

## Interface
- CHK_SPORT, 1, 1 = source port must equal cfg_port_pc; 0 = source port ignored
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- cfg_port_local  in  16  expected UDP destination port
- cfg_port_pc  in  16  expected UDP source port
- din  in  32  datagram word; byte 0 in [31:24]
- din_sop / din_eop / din_vld  in  1  word framing; word 0 = {sport, dport}, word 1 = {len, csum}
- din_mty  in  2  empty bytes on the eop word (low bytes invalid)
- din_rdy  out  1  word accepted when din_vld && din_rdy
- dout  out  16  payload; first byte in [15:8]
- dout_sop / dout_eop / dout_vld  out  1  payload framing
- dout_mty  out  1  on eop beat: 1 = only [15:8] valid
- dout_err  out  1  with dout_eop: payload truncated or aborted
- flag_port_err / flag_len_err  out  1  one-cycle pulses on datagram drop

## Operation
- States: IDLE, HDR1, PAYLOAD, DROP.
- IDLE: an accepted word with din_sop latches sport/dport, then goes to HDR1. Non-sop words are discarded.
- HDR1: the accepted word supplies len = din[31:16] and rem = len-8 (16-bit). Checksum is ignored.
  - Port mismatch (dport != cfg_port_local, or CHK_SPORT && sport != cfg_port_pc): pulse flag_port_err, go to DROP.
  - len < 8: pulse flag_len_err, go to DROP.
  - len == 8: go to DROP with no flag and no output.
  - Otherwise go to PAYLOAD.
  - din_eop in HDR1 means a header-only fragment: pulse flag_len_err, go to IDLE.
- Going to DROP while din_eop is on the same word goes directly to IDLE.
- PAYLOAD: valid bytes per word v = min(avail, rem), where avail = 4 - din_mty on eop words and 4 otherwise.
  - The word is loaded into a hold register and emitted as ceil(v/2) 16-bit beats.
  - rem decrements by v.
  - The first beat of a datagram carries dout_sop.
- Last beat gets dout_eop when rem reaches 0 or din_eop. dout_mty = 1 if that beat holds one byte.
- rem reaches 0 without din_eop: go to DROP (discard pad words until din_eop). With din_eop: go to IDLE.
- din_eop while rem > v: dout_err = 1 on the eop beat, go to IDLE.
- DROP: accept and discard words until din_eop, then go to IDLE.
- din_sop arriving in HDR1/PAYLOAD/DROP aborts the current datagram and restarts header parsing with that word.
  - If PAYLOAD had already emitted dout_sop, a terminator beat is emitted: dout_vld = dout_eop = dout_err = 1, dout = 0, dout_mty = 1.
- Header words never produce output beats.

## Timing
- Reset: state IDLE, hold empty, rem = 0. dout = 0, dout_sop/eop/vld/mty/err = 0, flags = 0, din_rdy = 1.
- All dout*/flag outputs are registered.
- din_rdy is combinational: low only while the hold register still has a second beat pending.
- Payload word accepted at cycle N:
  - high beat at N+1, din_rdy low during N+1;
  - low beat at N+2, din_rdy high at N+2, so the next word can be accepted at N+2.
- Sustained rate: one 16-bit beat per cycle.
- A word yielding one beat does not drop din_rdy.
- Flags pulse at cycle N+1 after the deciding word is accepted at N.
- Terminator beat appears at N+1 after the aborting sop is accepted at N.
- dout_vld never asserts without a preceding dout_sop in the same datagram. Exactly one dout_eop per dout_sop.
- rst mid-packet returns to reset values next cycle with no terminator beat.

## Test plan
- Ports match, len = 14, 6 payload bytes 01..06 over words 2-3 (mty = 2 on word 3) -> beats 0x0102 (sop), 0x0304, 0x0506 (eop, mty 0). din_rdy low exactly on cycles with a pending low beat.
- len = 13, 5 payload bytes followed by 22 pad bytes up to eop -> beats 0x0102 sop, 0x0304, 0x05xx eop with mty 1. Pad words accepted and discarded with no output.
- dport = 0x1234 vs cfg_port_local = 0x1F90 -> flag_port_err pulses once, no dout_vld. The next valid datagram is delivered intact.
- len = 5 -> flag_len_err pulses once; len = 8 -> no flag and no output; both return to IDLE on eop.
- len = 20 but din_eop after 8 payload bytes -> 4 beats, the last with dout_eop = dout_err = 1.
- din_sop mid-payload after 2 beats -> terminator beat (eop, err, mty 1). The new datagram is then parsed and output normally. Repeat with rst asserted mid-payload -> all outputs 0 next cycle.
